// File: rtl/issue_scoreboard.sv
// In-order N-way issue scoreboard: tracks in-flight register writes, selects the
// issuable prefix of the decode bundle and reports a bypass source per operand.
module issue_scoreboard #(
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned WB_AGE    = 3,
    parameter int unsigned LAT_W     = 2,
    parameter int unsigned FLUSH_AGE = 1,
    localparam int unsigned STG_W    = $clog2(WB_AGE + 1),
    localparam int unsigned LANE_W   = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             stall_i,
    input  logic                             flush_i,
    input  logic [ISSUE_W-1:0]               valid_i,
    input  logic [ISSUE_W-1:0][4:0]          rs1_i,
    input  logic [ISSUE_W-1:0][4:0]          rs2_i,
    input  logic [ISSUE_W-1:0][4:0]          rd_i,
    input  logic [ISSUE_W-1:0]               we_i,
    input  logic [ISSUE_W-1:0][LAT_W-1:0]    lat_i,
    input  logic [ISSUE_W-1:0]               early_i,
    output logic [ISSUE_W-1:0]               issue_o,
    output logic [ISSUE_W-1:0][STG_W-1:0]    fwd_stg1_o,
    output logic [ISSUE_W-1:0][LANE_W-1:0]   fwd_lane1_o,
    output logic [ISSUE_W-1:0][STG_W-1:0]    fwd_stg2_o,
    output logic [ISSUE_W-1:0][LANE_W-1:0]   fwd_lane2_o
);

    localparam int unsigned NREG = 32;
    // Lookup result layout: {hazard, stage, lane}
    localparam int unsigned LK_W = STG_W + LANE_W + 1;

    logic [NREG-1:0]              busy_q, busy_d;
    logic [NREG-1:0][STG_W-1:0]   age_q,  age_d;
    logic [NREG-1:0][LAT_W-1:0]   rem_q,  rem_d;
    logic [NREG-1:0][LANE_W-1:0]  lane_q, lane_d;

    logic [ISSUE_W-1:0]              ready_c;
    logic [ISSUE_W-1:0]              issue_c;
    logic [ISSUE_W-1:0][STG_W-1:0]   stg1_c, stg2_c;
    logic [ISSUE_W-1:0][LANE_W-1:0]  lane1_c, lane2_c;

    logic [LK_W-1:0] lk1, lk2;
    logic            haz;
    logic            chain;

    // Operand lookup against the scoreboard; a hazard reports stage/lane 0.
    function automatic logic [LK_W-1:0] lookup(input logic [4:0] src, input logic early);
        logic              h;
        logic [STG_W-1:0]  stg;
        logic [LANE_W-1:0] ln;
        h   = 1'b0;
        stg = '0;
        ln  = '0;
        if (src != 5'd0 && busy_q[src]) begin
            if (rem_q[src] != '0 || (early && age_q[src] < STG_W'(2))) begin
                h = 1'b1;
            end else begin
                stg = age_q[src];
                ln  = lane_q[src];
            end
        end
        return {h, stg, ln};
    endfunction

    // Per-lane readiness, issue prefix and forwarding selection.
    always_comb begin
        ready_c = '0;
        issue_c = '0;
        stg1_c  = '0;
        stg2_c  = '0;
        lane1_c = '0;
        lane2_c = '0;
        lk1     = '0;
        lk2     = '0;
        haz     = 1'b0;
        chain   = !stall_i && !flush_i;
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            lk1 = lookup(rs1_i[j], early_i[j]);
            lk2 = lookup(rs2_i[j], early_i[j]);
            haz = lk1[LK_W-1] | lk2[LK_W-1];
            for (int unsigned i = 0; i < ISSUE_W; i++) begin
                if (i < j && valid_i[i] && we_i[i] && rd_i[i] != 5'd0) begin
                    if (rd_i[i] == rs1_i[j] || rd_i[i] == rs2_i[j]) begin
                        haz = 1'b1;
                    end
                    if (we_i[j] && rd_i[i] == rd_i[j]) begin
                        haz = 1'b1;
                    end
                end
            end
            // An older producer of rd still in flight would be overwritten.
            if (we_i[j] && rd_i[j] != 5'd0 && busy_q[rd_i[j]]
                && age_q[rd_i[j]] < STG_W'(WB_AGE)) begin
                haz = 1'b1;
            end
            ready_c[j] = valid_i[j] & ~haz;
            chain      = chain & ready_c[j];
            issue_c[j] = chain;
            if (valid_i[j]) begin
                stg1_c[j]  = lk1[LK_W-2 -: STG_W];
                lane1_c[j] = lk1[LANE_W-1:0];
                stg2_c[j]  = lk2[LK_W-2 -: STG_W];
                lane2_c[j] = lk2[LANE_W-1:0];
            end
        end
    end

    // Next-state: flush kill, ageing/retire, then new entries from issued lanes.
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        rem_d  = rem_q;
        lane_d = lane_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (busy_q[r] && flush_i && age_q[r] <= STG_W'(FLUSH_AGE)) begin
                busy_d[r] = 1'b0;
                age_d[r]  = '0;
                rem_d[r]  = '0;
            end else if (busy_q[r] && !stall_i) begin
                if (age_q[r] == STG_W'(WB_AGE)) begin
                    busy_d[r] = 1'b0;
                    age_d[r]  = '0;
                    rem_d[r]  = '0;
                end else begin
                    age_d[r] = age_q[r] + 1'b1;
                    rem_d[r] = (rem_q[r] != '0) ? rem_q[r] - 1'b1 : '0;
                end
            end
        end
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            if (issue_c[j] && we_i[j] && rd_i[j] != 5'd0) begin
                busy_d[rd_i[j]] = 1'b1;
                age_d[rd_i[j]]  = STG_W'(1);
                rem_d[rd_i[j]]  = (lat_i[j] != '0) ? lat_i[j] - 1'b1 : '0;
                lane_d[rd_i[j]] = LANE_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
            age_q  <= '0;
            rem_q  <= '0;
            lane_q <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            rem_q  <= rem_d;
            lane_q <= lane_d;
        end
    end

    assign issue_o     = issue_c;
    assign fwd_stg1_o  = stg1_c;
    assign fwd_lane1_o = lane1_c;
    assign fwd_stg2_o  = stg2_c;
    assign fwd_lane2_o = lane2_c;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed pipeline scenarios plus randomized bundles
// checked against a timestamp-based model of in-flight register writes.
module tb_issue_scoreboard;

    localparam int ISSUE_W   = 2;
    localparam int WB_AGE    = 3;
    localparam int LAT_W     = 2;
    localparam int FLUSH_AGE = 1;
    localparam int STG_W     = 2;
    localparam int LANE_W    = 1;

    logic clk = 1'b0;
    logic resetn;
    logic stall_i, flush_i;
    logic [ISSUE_W-1:0]             valid_i, we_i, early_i, issue_o;
    logic [ISSUE_W-1:0][4:0]        rs1_i, rs2_i, rd_i;
    logic [ISSUE_W-1:0][LAT_W-1:0]  lat_i;
    logic [ISSUE_W-1:0][STG_W-1:0]  fwd_stg1_o, fwd_stg2_o;
    logic [ISSUE_W-1:0][LANE_W-1:0] fwd_lane1_o, fwd_lane2_o;

    always #5 clk = ~clk;

    issue_scoreboard #(
        .ISSUE_W(ISSUE_W), .WB_AGE(WB_AGE), .LAT_W(LAT_W), .FLUSH_AGE(FLUSH_AGE)
    ) dut (
        .clk(clk), .resetn(resetn), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .we_i(we_i), .lat_i(lat_i), .early_i(early_i), .issue_o(issue_o),
        .fwd_stg1_o(fwd_stg1_o), .fwd_lane1_o(fwd_lane1_o),
        .fwd_stg2_o(fwd_stg2_o), .fwd_lane2_o(fwd_lane2_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the current cycle
    bit tv[ISSUE_W], twe[ISSUE_W], tearly[ISSUE_W];
    int trs1[ISSUE_W], trs2[ISSUE_W], trd[ISSUE_W], tlat[ISSUE_W];
    bit tst, tfl;

    // Model: each register remembers when (in unstalled cycles) its producer issued
    bit m_valid[32];
    int m_t[32], m_lat[32], m_lane[32];
    int tnow;

    int exp_issue;
    bit exp_oh[ISSUE_W][2];
    int exp_stg[ISSUE_W][2], exp_ln[ISSUE_W][2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_age(int r);
        return tnow - m_t[r];
    endfunction

    function automatic bit m_busy(int r);
        return r != 0 && m_valid[r] && m_age(r) <= WB_AGE;
    endfunction

    function automatic int m_rem(int r);
        int l, v;
        l = (m_lat[r] == 0) ? 1 : m_lat[r];
        v = l - m_age(r);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_valid[r] = 1'b0;
        tnow = 100;
    endtask

    task automatic idle();
        for (int j = 0; j < ISSUE_W; j++) begin
            tv[j] = 0; twe[j] = 0; tearly[j] = 0;
            trs1[j] = 0; trs2[j] = 0; trd[j] = 0; tlat[j] = 0;
        end
        tst = 0; tfl = 0;
    endtask

    task automatic set_lane(input int j, input bit we, input int rd, input int rs1,
                            input int rs2, input int lat, input bit early);
        tv[j] = 1; twe[j] = we; trd[j] = rd; trs1[j] = rs1; trs2[j] = rs2;
        tlat[j] = lat; tearly[j] = early;
    endtask

    task automatic apply();
        for (int j = 0; j < ISSUE_W; j++) begin
            valid_i[j] = tv[j];
            we_i[j]    = twe[j];
            early_i[j] = tearly[j];
            rs1_i[j]   = 5'(trs1[j]);
            rs2_i[j]   = 5'(trs2[j]);
            rd_i[j]    = 5'(trd[j]);
            lat_i[j]   = LAT_W'(tlat[j]);
        end
        stall_i = tst;
        flush_i = tfl;
    endtask

    task automatic predict();
        bit chain, haz;
        int s;
        chain = !tst && !tfl;
        exp_issue = 0;
        for (int j = 0; j < ISSUE_W; j++) begin
            haz = 0;
            for (int k = 0; k < 2; k++) begin
                s = (k == 0) ? trs1[j] : trs2[j];
                exp_oh[j][k] = 0; exp_stg[j][k] = 0; exp_ln[j][k] = 0;
                if (m_busy(s)) begin
                    if (m_rem(s) > 0 || (tearly[j] && m_age(s) < 2)) exp_oh[j][k] = 1;
                    else begin
                        exp_stg[j][k] = m_age(s);
                        exp_ln[j][k]  = m_lane[s];
                    end
                end
                for (int i = 0; i < j; i++)
                    if (tv[i] && twe[i] && trd[i] != 0 && trd[i] == s) haz = 1;
                haz |= exp_oh[j][k];
            end
            if (twe[j] && trd[j] != 0) begin
                if (m_busy(trd[j]) && m_age(trd[j]) < WB_AGE) haz = 1;
                for (int i = 0; i < j; i++)
                    if (tv[i] && twe[i] && trd[i] == trd[j]) haz = 1;
            end
            chain = chain && tv[j] && !haz;
            if (chain) exp_issue |= (1 << j);
        end
    endtask

    task automatic compare();
        int os, ol;
        chk("issue", int'(issue_o), exp_issue);
        for (int j = 0; j < ISSUE_W; j++) begin
            for (int k = 0; k < 2; k++) begin
                os = (k == 0) ? int'(fwd_stg1_o[j]) : int'(fwd_stg2_o[j]);
                ol = (k == 0) ? int'(fwd_lane1_o[j]) : int'(fwd_lane2_o[j]);
                if (!tv[j]) begin
                    chk($sformatf("idle_stg%0d_l%0d", k + 1, j), os, 0);
                    chk($sformatf("idle_lane%0d_l%0d", k + 1, j), ol, 0);
                end else if (!exp_oh[j][k]) begin
                    chk($sformatf("stg%0d_l%0d", k + 1, j), os, exp_stg[j][k]);
                    chk($sformatf("lane%0d_l%0d", k + 1, j), ol, exp_ln[j][k]);
                end
            end
        end
    endtask

    task automatic m_update();
        if (tfl)
            for (int r = 1; r < 32; r++)
                if (m_busy(r) && m_age(r) <= FLUSH_AGE) m_valid[r] = 0;
        if (!tst) begin
            for (int j = 0; j < ISSUE_W; j++)
                if (exp_issue[j] && twe[j] && trd[j] != 0) begin
                    m_valid[trd[j]] = 1;
                    m_t[trd[j]]     = tnow;
                    m_lat[trd[j]]   = tlat[j];
                    m_lane[trd[j]]  = j;
                end
            tnow++;
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        apply();
        #1;
        predict();
        compare();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        m_update();
    endtask

    task automatic step();
        cyc_begin();
        cyc_end();
    endtask

    task automatic drain();
        repeat (4) begin
            idle();
            step();
        end
    endtask

    initial begin
        idle();
        apply();
        m_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_issue", int'(issue_o), 0);
        chk("rst_stg1", int'(fwd_stg1_o), 0);
        resetn = 1'b1;

        // ALU bypass
        idle(); set_lane(0, 1, 5, 0, 0, 1, 0);
        cyc_begin(); chk("t1_wr_issue", int'(issue_o), 1); cyc_end();
        idle(); set_lane(0, 0, 0, 5, 0, 1, 0);
        cyc_begin(); chk("t1_rd_issue", int'(issue_o), 1);
        chk("t1_rd_stg", int'(fwd_stg1_o[0]), 1); chk("t1_rd_lane", int'(fwd_lane1_o[0]), 0); cyc_end();
        idle(); step(); step();
        idle(); set_lane(0, 0, 0, 5, 0, 1, 0);
        cyc_begin(); chk("t1_rf_stg", int'(fwd_stg1_o[0]), 0); chk("t1_rf_issue", int'(issue_o), 1); cyc_end();
        drain();

        // Load-use from lane 1
        idle(); set_lane(0, 0, 0, 0, 0, 1, 0); set_lane(1, 1, 6, 0, 0, 2, 0);
        cyc_begin(); chk("t2_wr_issue", int'(issue_o), 3); cyc_end();
        idle(); set_lane(0, 0, 0, 0, 6, 1, 0);
        cyc_begin(); chk("t2_use_stall", int'(issue_o), 0); cyc_end();
        cyc_begin(); chk("t2_use_issue", int'(issue_o), 1);
        chk("t2_use_stg", int'(fwd_stg2_o[0]), 2); chk("t2_use_lane", int'(fwd_lane2_o[0]), 1); cyc_end();
        drain();

        // Intra-bundle RAW and WAW
        idle(); set_lane(0, 1, 7, 0, 0, 1, 0); set_lane(1, 0, 0, 7, 0, 1, 0);
        cyc_begin(); chk("t3_raw_issue", int'(issue_o), 1); cyc_end();
        idle(); set_lane(0, 0, 0, 7, 0, 1, 0);
        cyc_begin(); chk("t3_fwd_stg", int'(fwd_stg1_o[0]), 1); chk("t3_fwd_lane", int'(fwd_lane1_o[0]), 0); cyc_end();
        idle(); set_lane(0, 1, 8, 0, 0, 1, 0); set_lane(1, 1, 8, 0, 0, 1, 0);
        cyc_begin(); chk("t3_waw_issue", int'(issue_o), 1); cyc_end();
        drain();

        // Early operand
        idle(); set_lane(0, 1, 8, 0, 0, 1, 0);
        step();
        idle(); set_lane(0, 0, 0, 8, 0, 1, 1);
        cyc_begin(); chk("t4_early_stall", int'(issue_o), 0); cyc_end();
        cyc_begin(); chk("t4_early_issue", int'(issue_o), 1); chk("t4_early_stg", int'(fwd_stg1_o[0]), 2); cyc_end();
        idle(); set_lane(0, 0, 0, 0, 0, 1, 1); set_lane(1, 0, 0, 0, 0, 1, 1);
        cyc_begin(); chk("t4_x0_issue", int'(issue_o), 3); cyc_end();
        drain();

        // Flush kills speculative producer; age-2 survives
        idle(); set_lane(0, 1, 9, 0, 0, 2, 0);
        step();
        idle(); tfl = 1; set_lane(0, 0, 0, 9, 0, 1, 0);
        cyc_begin(); chk("t5_flush_issue", int'(issue_o), 0); cyc_end();
        idle(); set_lane(0, 0, 0, 9, 0, 1, 0);
        cyc_begin(); chk("t5_post_stg", int'(fwd_stg1_o[0]), 0); chk("t5_post_issue", int'(issue_o), 1); cyc_end();
        idle(); set_lane(0, 1, 11, 0, 0, 1, 0); step();
        idle(); set_lane(0, 1, 12, 0, 0, 1, 0); step();
        idle(); tfl = 1; step();
        idle(); set_lane(0, 0, 0, 11, 12, 1, 0);
        cyc_begin(); chk("t5_surv_stg", int'(fwd_stg1_o[0]), 3); chk("t5_kill_stg", int'(fwd_stg2_o[0]), 0);
        chk("t5_surv_issue", int'(issue_o), 1); cyc_end();
        drain();

        // Stall freeze
        idle(); set_lane(0, 1, 10, 0, 0, 3, 0); step();
        for (int c = 1; c <= 5; c++) begin
            idle(); tst = (c <= 2); set_lane(0, 0, 0, 10, 0, 1, 0);
            cyc_begin();
            chk($sformatf("t6_c%0d_issue", c), int'(issue_o), (c == 5) ? 1 : 0);
            if (c == 5) chk("t6_stg", int'(fwd_stg1_o[0]), 3);
            cyc_end();
        end
        drain();

        // Async reset mid-flight
        idle(); set_lane(0, 1, 10, 0, 0, 3, 0); step();
        idle(); set_lane(0, 0, 0, 10, 0, 1, 0);
        @(negedge clk); apply(); #1;
        chk("t6_pre_rst_issue", int'(issue_o), 0);
        #2 resetn = 1'b0; #1;
        chk("t6_rst_stg", int'(fwd_stg1_o[0]), 0);
        chk("t6_rst_issue", int'(issue_o), 1);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Randomized bundles
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < ISSUE_W; j++) begin
                tv[j]     = $urandom_range(0, 3) != 0;
                twe[j]    = $urandom_range(0, 3) != 0;
                tearly[j] = $urandom_range(0, 3) == 0;
                trd[j]    = $urandom_range(0, 7);
                trs1[j]   = $urandom_range(0, 7);
                trs2[j]   = $urandom_range(0, 7);
                tlat[j]   = $urandom_range(0, 3);
            end
            tst = $urandom_range(0, 7) == 0;
            tfl = $urandom_range(0, 11) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
